// File: rtl/raster_tri_sched.sv
// Round-robin triangle scheduler feeding the shared rasterizer command port.
// Optional back-face/degenerate culling is compiled in with RASTER_CULL_EN.
module raster_tri_sched #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*192-1:0]     req_vtx,
  output logic                       cmd_valid,
  output logic [2:0]                 cmd_type,
  output logic [31:0]                cmd_data_x,
  output logic [31:0]                cmd_data_y,
  input  logic                       cmd_ready,
  input  logic                       rast_busy,
  output logic                       done_valid,
  output logic [$clog2(NUM_REQ)-1:0] done_id,
  output logic                       done_culled,
  output logic                       timeout_err,
  output logic [31:0]                tri_count,
  output logic [2:0]                 state_dbg
);

  // Command handshake: a command is transferred on a rising clk edge where
  // cmd_valid && cmd_ready; while cmd_valid is high and cmd_ready is low,
  // cmd_type/cmd_data_x/cmd_data_y hold their values.

  localparam int IDW = $clog2(NUM_REQ);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_V0    = 3'd2;
  localparam logic [2:0] S_V1    = 3'd3;
  localparam logic [2:0] S_V2    = 3'd4;
  localparam logic [2:0] S_DRAW  = 3'd5;
  localparam logic [2:0] S_WAIT  = 3'd6;

  localparam logic [2:0] CMD_V0   = 3'b001;
  localparam logic [2:0] CMD_V1   = 3'b010;
  localparam logic [2:0] CMD_V2   = 3'b011;
  localparam logic [2:0] CMD_DRAW = 3'b100;

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

`ifdef RASTER_CULL_EN
  localparam logic [2:0] S_CULL = 3'd7;
  localparam int VTX_LO = 0;
`else
  // Without culling, v0 goes straight from the requester to the command port.
  localparam int VTX_LO = 64;
`endif

  logic [2:0]        state;
  logic [IDW-1:0]    grant_id;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    sel;
  logic              found;
  logic [191:0]      gslice;
  logic [191:VTX_LO] vtx;
  logic [15:0]       wdog;
  logic [15:0]       wdog_inc;
  logic              wait_first;

  assign state_dbg = state;
  assign wdog_inc  = wdog + 16'd1;

  always_comb begin
    gslice = req_vtx[int'(grant_id)*192 +: 192];
  end

  // First pending requester after the last winner, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        sel   = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

`ifdef RASTER_CULL_EN
  logic               cull_phase;
  logic signed [63:0] prod_a;
  logic signed [63:0] prod_b;
  logic signed [63:0] area;
  logic signed [63:0] d1x, d1y, d2x, d2y;

  function automatic logic signed [63:0] sx(input logic [31:0] a);
    return {{32{a[31]}}, a};
  endfunction

  always_comb begin
    d1x  = sx(vtx[95:64])   - sx(vtx[31:0]);
    d1y  = sx(vtx[127:96])  - sx(vtx[63:32]);
    d2x  = sx(vtx[159:128]) - sx(vtx[31:0]);
    d2y  = sx(vtx[191:160]) - sx(vtx[63:32]);
    area = prod_a - prod_b;
  end
`else
  assign done_culled = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      grant_id    <= '0;
      rr_ptr      <= IDW'(NUM_REQ - 1);
      vtx         <= '0;
      wdog        <= '0;
      wait_first  <= 1'b0;
      req_ready   <= '0;
      cmd_valid   <= 1'b0;
      cmd_type    <= 3'b000;
      cmd_data_x  <= '0;
      cmd_data_y  <= '0;
      done_valid  <= 1'b0;
      done_id     <= '0;
      timeout_err <= 1'b0;
      tri_count   <= '0;
`ifdef RASTER_CULL_EN
      done_culled <= 1'b0;
      cull_phase  <= 1'b0;
      prod_a      <= '0;
      prod_b      <= '0;
`endif
    end else begin
      req_ready  <= '0;
      done_valid <= 1'b0;
`ifdef RASTER_CULL_EN
      done_culled <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_id  <= sel;
            req_ready <= NUM_REQ'(1) << sel;
            state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          vtx    <= gslice[191:VTX_LO];
          rr_ptr <= grant_id;
`ifdef RASTER_CULL_EN
          cull_phase <= 1'b0;
          state      <= S_CULL;
`else
          cmd_valid  <= 1'b1;
          cmd_type   <= CMD_V0;
          cmd_data_x <= gslice[31:0];
          cmd_data_y <= gslice[63:32];
          state      <= S_V0;
`endif
        end
`ifdef RASTER_CULL_EN
        S_CULL: begin
          if (!cull_phase) begin
            prod_a     <= d1x * d2y;
            prod_b     <= d1y * d2x;
            cull_phase <= 1'b1;
          end else if (area <= 64'sd0) begin
            done_valid  <= 1'b1;
            done_culled <= 1'b1;
            done_id     <= grant_id;
            state       <= S_IDLE;
          end else begin
            cmd_valid  <= 1'b1;
            cmd_type   <= CMD_V0;
            cmd_data_x <= vtx[31:0];
            cmd_data_y <= vtx[63:32];
            state      <= S_V0;
          end
        end
`endif
        S_V0: begin
          if (cmd_ready) begin
            cmd_type   <= CMD_V1;
            cmd_data_x <= vtx[95:64];
            cmd_data_y <= vtx[127:96];
            state      <= S_V1;
          end
        end
        S_V1: begin
          if (cmd_ready) begin
            cmd_type   <= CMD_V2;
            cmd_data_x <= vtx[159:128];
            cmd_data_y <= vtx[191:160];
            state      <= S_V2;
          end
        end
        S_V2: begin
          if (cmd_ready) begin
            cmd_type   <= CMD_DRAW;
            cmd_data_x <= '0;
            cmd_data_y <= '0;
            state      <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (cmd_ready) begin
            cmd_valid  <= 1'b0;
            cmd_type   <= 3'b000;
            tri_count  <= tri_count + 32'd1;
            wdog       <= '0;
            wait_first <= 1'b1;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Busy is only trusted from the second cycle; the rasterizer
          // raises it one cycle after accepting DRAW.
          wdog       <= wdog_inc;
          wait_first <= 1'b0;
          if (!wait_first && !rast_busy) begin
            done_valid <= 1'b1;
            done_id    <= grant_id;
            state      <= S_IDLE;
          end else if (wdog_inc == TMO) begin
            timeout_err <= 1'b1;
            done_valid  <= 1'b1;
            done_id     <= grant_id;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_tri_sched.sv
// Directed self-checking bench for raster_tri_sched with a command scoreboard.
// Runs with NUM_REQ=4 and a 16-cycle watchdog; cull test needs RASTER_CULL_EN.
module tb_raster_tri_sched;

  localparam int NUM_REQ = 4;
  localparam int TMO     = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_REQ-1:0]     req_valid = '0;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*192-1:0] req_vtx = '0;
  logic                   cmd_valid;
  logic [2:0]             cmd_type;
  logic [31:0]            cmd_data_x;
  logic [31:0]            cmd_data_y;
  logic                   cmd_ready = 1'b1;
  logic                   rast_busy = 1'b0;
  logic                   done_valid;
  logic [1:0]             done_id;
  logic                   done_culled;
  logic                   timeout_err;
  logic [31:0]            tri_count;
  logic [2:0]             state_dbg;

  int          n_checks = 0;
  int          n_fail = 0;
  int          overlap_cnt = 0;
  int          cmd_hs = 0;
  logic [66:0] exp_q[$];
  logic [66:0] mon_e;

  raster_tri_sched #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_vtx(req_vtx),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_data_x(cmd_data_x), .cmd_data_y(cmd_data_y),
    .cmd_ready(cmd_ready), .rast_busy(rast_busy),
    .done_valid(done_valid), .done_id(done_id), .done_culled(done_culled),
    .timeout_err(timeout_err), .tri_count(tri_count), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic set_slice(input int i, input int v0x, input int v0y, input int v1x,
                           input int v1y, input int v2x, input int v2y);
    req_vtx[192*i +: 192] = {v2y, v2x, v1y, v1x, v0y, v0x};
  endtask

  task automatic push_tri(input int v0x, input int v0y, input int v1x,
                          input int v1y, input int v2x, input int v2y);
    exp_q.push_back({3'b001, v0x, v0y});
    exp_q.push_back({3'b010, v1x, v1y});
    exp_q.push_back({3'b011, v2x, v2y});
    exp_q.push_back({3'b100, 64'd0});
  endtask

  task automatic after_grant();
    tick();
`ifdef RASTER_CULL_EN
    tick();
    tick();
`endif
  endtask

  task automatic wait_grant(output int id);
    int n;
    n  = 0;
    id = -1;
    do begin
      tick();
      n++;
    end while (req_ready == '0 && n < 60);
    check("grant_seen", 128'(req_ready != '0), 128'd1);
    check("grant_onehot", 128'($countones(req_ready)), 128'd1);
    for (int b = 0; b < NUM_REQ; b++) if (req_ready[b]) id = b;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done_valid && n < 60);
    check("done_seen", 128'(done_valid), 128'd1);
  endtask

  // scoreboard: every accepted command must match the next expected one
  always @(negedge clk) begin
    if (rst_n && done_valid && (req_ready != '0)) overlap_cnt++;
    if (rst_n && cmd_valid && cmd_ready) begin
      cmd_hs++;
      if (exp_q.size() == 0) begin
        check("cmd_unexpected", 128'(exp_q.size()), 128'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("cmd_seq", 128'({cmd_type, cmd_data_x, cmd_data_y}), 128'(mon_e));
      end
    end
  end

  initial begin
    int id;
    logic early;

    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_outputs", 128'({req_ready, cmd_valid, cmd_type, cmd_data_x, cmd_data_y}), 128'd0);
    check("rst_status", 128'({done_valid, done_id, done_culled, timeout_err, tri_count}), 128'd0);
    check("rst_state", 128'(state_dbg), 128'd0);

    // single request, exact timing
    set_slice(0, 0, 0, 8, 0, 0, 8);
    push_tri(0, 0, 8, 0, 0, 8);
    req_valid = 4'b0001;
    tick();
    check("t1_req_ready", 128'(req_ready), 128'h1);
    check("t1_no_cmd_in_grant", 128'(cmd_valid), 128'd0);
    after_grant();
    req_valid = '0;
    check("t1_v0", 128'({cmd_valid, cmd_type, cmd_data_x, cmd_data_y}), {61'd0, 1'b1, 3'b001, 32'd0, 32'd0});
    check("t1_req_ready_drop", 128'(req_ready), 128'd0);
    tick();
    check("t1_v1", 128'({cmd_valid, cmd_type, cmd_data_x, cmd_data_y}), {61'd0, 1'b1, 3'b010, 32'd8, 32'd0});
    tick();
    check("t1_v2", 128'({cmd_valid, cmd_type, cmd_data_x, cmd_data_y}), {61'd0, 1'b1, 3'b011, 32'd0, 32'd8});
    tick();
    check("t1_draw", 128'({cmd_valid, cmd_type, cmd_data_x, cmd_data_y}), {61'd0, 1'b1, 3'b100, 32'd0, 32'd0});
    tick();
    check("t1_cmd_drop", 128'(cmd_valid), 128'd0);
    check("t1_tri_count", 128'(tri_count), 128'd1);
    rast_busy = 1'b1;
    early = 1'b0;
    repeat (10) begin
      tick();
      if (done_valid) early = 1'b1;
    end
    check("t1_no_early_done", 128'(early), 128'd0);
    rast_busy = 1'b0;
    tick();
    check("t1_done_valid", 128'(done_valid), 128'd1);
    check("t1_done_id", 128'(done_id), 128'd0);
    check("t1_done_culled", 128'(done_culled), 128'd0);
    tick();
    check("t1_done_pulse", 128'(done_valid), 128'd0);

    // round-robin from reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_slice(i, i*100+1, 2, i*100+50, 2, i*100+1, 60);
    for (int k = 0; k < 5; k++) push_tri((k%4)*100+1, 2, (k%4)*100+50, 2, (k%4)*100+1, 60);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(id);
      check("rr_order", 128'(id), 128'(k % 4));
    end
    tick();
    req_valid = '0;
    wait_done();
    check("rr_done_id", 128'(done_id), 128'd0);
    check("rr_tri_count", 128'(tri_count), 128'd5);

    // backpressure on SET_V1
    set_slice(2, 5, -3, -7, 11, -20, -40);
    push_tri(5, -3, -7, 11, -20, -40);
    req_valid = 4'b0100;
    tick();
    check("bp_req_ready", 128'(req_ready), 128'h4);
    after_grant();
    req_valid = '0;
    tick();
    check("bp_v1", 128'({cmd_valid, cmd_type, cmd_data_x, cmd_data_y}), {61'd0, 1'b1, 3'b010, -32'sd7, 32'sd11});
    cmd_ready = 1'b0;
    repeat (3) begin
      tick();
      check("bp_v1_hold", 128'({cmd_valid, cmd_type, cmd_data_x, cmd_data_y}), {61'd0, 1'b1, 3'b010, -32'sd7, 32'sd11});
    end
    cmd_ready = 1'b1;
    tick();
    check("bp_v2", 128'({cmd_valid, cmd_type, cmd_data_x, cmd_data_y}), {61'd0, 1'b1, 3'b011, -32'sd20, -32'sd40});
    wait_done();
    check("bp_done_id", 128'(done_id), 128'd2);
    check("bp_tri_count", 128'(tri_count), 128'd6);

    // watchdog with busy stuck high
    rast_busy = 1'b1;
    set_slice(1, 1, 2, 30, 2, 1, 40);
    push_tri(1, 2, 30, 2, 1, 40);
    req_valid = 4'b0010;
    tick();
    check("wd_req_ready", 128'(req_ready), 128'h2);
    after_grant();
    req_valid = '0;
    tick();
    tick();
    tick();
    check("wd_draw", 128'({cmd_valid, cmd_type}), 128'({1'b1, 3'b100}));
    tick();
    check("wd_tri_count", 128'(tri_count), 128'd7);
    early = 1'b0;
    repeat (TMO - 1) begin
      tick();
      if (done_valid || timeout_err) early = 1'b1;
    end
    check("wd_no_early", 128'(early), 128'd0);
    tick();
    check("wd_done_valid", 128'(done_valid), 128'd1);
    check("wd_timeout_err", 128'(timeout_err), 128'd1);
    check("wd_done_id", 128'(done_id), 128'd1);
    tick();
    check("wd_done_pulse", 128'(done_valid), 128'd0);
    check("wd_sticky", 128'(timeout_err), 128'd1);
    rast_busy = 1'b0;
    set_slice(3, 7, 7, 20, 7, 7, 30);
    push_tri(7, 7, 20, 7, 7, 30);
    req_valid = 4'b1000;
    wait_grant(id);
    check("wd_next_grant", 128'(id), 128'd3);
    tick();
    req_valid = '0;
    wait_done();
    check("wd_next_done_id", 128'(done_id), 128'd3);
    check("wd_next_tri_count", 128'(tri_count), 128'd8);
    check("wd_still_sticky", 128'(timeout_err), 128'd1);

    // reset while SET_V2 is pending
    exp_q.push_back({3'b001, 32'd1, 32'd2});
    exp_q.push_back({3'b010, 32'd30, 32'd2});
    req_valid = 4'b0010;
    tick();
    after_grant();
    req_valid = '0;
    tick();
    tick();
    cmd_ready = 1'b0;
    check("rs_in_v2", 128'({cmd_valid, cmd_type}), 128'({1'b1, 3'b011}));
    rst_n = 1'b0;
    tick();
    check("rs_cmd_zero", 128'({req_ready, cmd_valid, cmd_type, cmd_data_x, cmd_data_y}), 128'd0);
    check("rs_status_zero", 128'({done_valid, done_id, done_culled, timeout_err, tri_count}), 128'd0);
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    set_slice(0, 0, 0, 8, 0, 0, 8);
    push_tri(0, 0, 8, 0, 0, 8);
    req_valid = 4'b1001;
    wait_grant(id);
    check("rs_first_grant", 128'(id), 128'd0);
    tick();
    req_valid = '0;
    wait_done();
    check("rs_done_id", 128'(done_id), 128'd0);
    check("rs_tri_count", 128'(tri_count), 128'd1);

`ifdef RASTER_CULL_EN
    // clockwise triangle is culled without any command
    id = cmd_hs;
    set_slice(2, 0, 0, 0, 8, 8, 0);
    req_valid = 4'b0100;
    wait_grant(id);
    check("cull_grant", 128'(id), 128'd2);
    id = cmd_hs;
    tick();
    req_valid = '0;
    wait_done();
    check("cull_flag", 128'(done_culled), 128'd1);
    check("cull_done_id", 128'(done_id), 128'd2);
    check("cull_tri_count", 128'(tri_count), 128'd1);
    check("cull_no_cmd", 128'(cmd_hs), 128'(id));
`endif

    tick();
    check("exp_q_drained", 128'(exp_q.size()), 128'd0);
    check("done_ready_overlap", 128'(overlap_cnt), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/raster_tri_sched.md
Name: raster_tri_sched

Overview:
- Arbitrates triangle draw requests from NUM_REQ shader/compute requesters and sequences them into the raster unit's command port: SET_V0, SET_V1, SET_V2, then DRAW.
- Waits for the raster unit's busy to clear before signalling completion to the owning requester.
- Sits between the per-core draw queues and the single shared rasterizer.
- Provides a hang watchdog and a drawn-triangle counter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 65535, maximum cycles spent in WAIT_DONE before a timeout is flagged (1..65535).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester triangle request
- req_ready  out  NUM_REQ  one-hot accept pulse
- req_vtx  in  NUM_REQ*192  per-requester slice {v2_y,v2_x,v1_y,v1_x,v0_y,v0_x}, 32 b each, signed integer pixels; slice i at [192*i +: 192]
- cmd_valid  out  1  raster command valid
- cmd_type  out  3  001 SET_V0, 010 SET_V1, 011 SET_V2, 100 DRAW
- cmd_data_x  out  32  command x
- cmd_data_y  out  32  command y
- cmd_ready  in  1  raster command ready
- rast_busy  in  1  raster unit busy
- done_valid  out  1  one-cycle completion pulse
- done_id  out  $clog2(NUM_REQ)  owner of the completed triangle
- done_culled  out  1  completed triangle was culled; tied 0 without RASTER_CULL_EN
- timeout_err  out  1  sticky watchdog error
- tri_count  out  32  triangles for which DRAW was issued; wraps

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr = NUM_REQ-1, so requester 0 has top priority first.
- State machine: IDLE -> GRANT -> [CULL] -> V0 -> V1 -> V2 -> DRAW -> WAIT_DONE -> IDLE.
- IDLE: if any req_valid is set, pick the first set bit scanning from rr_ptr+1 with wrap. Register grant_id and go to GRANT.
- GRANT: exactly one cycle.
  - req_ready[grant_id] = 1.
  - Latch that requester's 192-bit slice and set rr_ptr = grant_id.
  - Go to V0, or to CULL when the macro is defined.
  - req_valid is guaranteed held from IDLE through GRANT (requester rule).
- V0/V1/V2/DRAW:
  - cmd_valid = 1 with the matching cmd_type and coordinates; DRAW carries x=y=0.
  - Outputs are registered and stable until the cycle cmd_valid && cmd_ready.
  - Advance on that handshake; cmd_valid drops only if the next state issues no command.
  - Back-to-back commands are allowed. Minimum is 4 cycles for the four commands when cmd_ready stays high.
- DRAW handshake: tri_count increments (mod 2^32). The watchdog counter clears to 0.
- WAIT_DONE:
  - The first cycle after entry ignores rast_busy, because the raster unit raises busy one cycle after accepting DRAW.
  - From the second cycle, rast_busy == 0 causes: done_valid = 1, done_id = grant_id, done_culled = 0, go to IDLE.
  - The watchdog increments each cycle in this state. On reaching TIMEOUT_CYCLES:
    - set timeout_err (sticky until reset);
    - force completion with done_valid = 1 and return to IDLE.
- Latency: from req_valid rising with the scheduler idle and cmd_ready high, req_ready follows 1 cycle later and the first command 2 cycles later.
- Fairness: a continuously requesting requester is not re-granted while another requester is pending.
- req_valid changing while the scheduler is not in IDLE has no effect.
- Reset asserted mid-triangle: immediate abort.
  - cmd_valid drops and no done pulse is generated.
  - The raster unit is reset by the same rst_n.
- done_valid is never asserted in the same cycle as req_ready.

Optional Feature:
- Macro RASTER_CULL_EN.
- When defined, the CULL state computes area = (v1x-v0x)*(v2y-v0y) - (v1y-v0y)*(v2x-v0x), using 64-bit signed intermediates registered in one cycle.
  - If area <= 0 (back-facing or degenerate): no commands are issued; done_valid = 1, done_culled = 1, done_id = grant_id; tri_count is unchanged; go to IDLE.
  - Otherwise go to V0.
- When undefined: there is no CULL state and no multiplier, and done_culled is constant 0.

Test Plan:
- Single request: req 0 with vertices (0,0), (8,0), (0,8); cmd_ready = 1; rast_busy high for 10 cycles after DRAW -> commands 001, 010, 011, 100 on 4 consecutive cycles with the correct x/y; done_valid with done_id = 0 after busy falls; tri_count = 1.
- Round-robin: req_valid = 4'b1111 held -> grant order 0, 1, 2, 3, 0; req_ready is one-hot each time.
- Backpressure: cmd_ready low for 3 cycles during SET_V1 -> cmd_type/x/y stay stable; no command is skipped or duplicated.
- Watchdog: TIMEOUT_CYCLES = 16 with rast_busy stuck at 1 -> timeout_err set after 16 WAIT_DONE cycles; done_valid pulses; the next request is still serviced.
- Cull (RASTER_CULL_EN): req 2 with clockwise vertices (0,0), (0,8), (8,0) -> no cmd_valid; done_valid with done_culled = 1 and done_id = 2; tri_count unchanged.
- Reset asserted during the V2 command -> all outputs 0 next cycle; after release, requester 0 is granted first.
